trp_feeder: RTL and testbench

Transaction-level initiator for the transpose/reduction unit (`trp_unit`). It accepts one multi-beat vector request and streams it, one `8*WIDTH`-bit beat per cycle, into the unit's `en`/`a`/`mode` port, honouring `busy`. It then waits for the unit's `valid`, acknowledges the result with `read`, and returns it to the requester over a valid/ready response channel. It sits between the vector-lane issue logic and `trp_unit`.

---
 rtl/trp_feeder.sv | 94 +++++++++
 tb/tb_trp_feeder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trp_feeder.sv
// trp_feeder: streams one multi-beat vector request into trp_unit, waits for its result and returns it over a valid/ready response channel
// Ports: req_* request channel (valid/ready, mode, length, packed beats); trp_* trp_unit beat/result interface;
//        rsp_* response channel (valid/ready, data, error flag); err sticky protocol error (stray trp_valid)
module trp_feeder #(
  parameter int WIDTH   = 4,
  parameter int NBEATS  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_mode,
  input  logic [$clog2(NBEATS):0]   req_len,
  input  logic [8*WIDTH*NBEATS-1:0] req_data,
  output logic                      trp_en,
  output logic [8*WIDTH-1:0]        trp_a,
  output logic [1:0]                trp_mode,
  output logic                      trp_read,
  input  logic                      trp_busy,
  input  logic                      trp_valid,
  input  logic [8*WIDTH-1:0]        trp_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [8*WIDTH-1:0]        rsp_data,
  output logic                      rsp_err,
  output logic                      err
);
  localparam int BW = 8 * WIDTH;
  localparam int LW = $clog2(NBEATS) + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                state_q;
  logic [BW*NBEATS-1:0]  data_q;
  logic [1:0]            mode_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         idx_q;
  logic [CW-1:0]         cnt_q;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == DONE;
  assign trp_en    = state_q == ISSUE && !trp_busy;
  assign trp_read  = state_q == WAIT && trp_valid;
  assign trp_a     = state_q == ISSUE ? data_q[int'(idx_q)*BW +: BW] : '0;
  assign trp_mode  = state_q != IDLE ? mode_q : 2'b00;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      mode_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      err      <= 1'b0;
    end else begin
      // a result outside WAIT has no transaction to belong to (including one arriving after a timeout)
      if (trp_valid && state_q != WAIT) err <= 1'b1;
      case (state_q)
        IDLE: if (req_valid) begin
          data_q   <= req_data;
          mode_q   <= req_mode;
          len_q    <= req_len > LW'(NBEATS) ? LW'(NBEATS) : req_len;
          idx_q    <= '0;
          rsp_data <= '0;
          rsp_err  <= req_len == '0;
          state_q  <= req_len == '0 ? DONE : ISSUE;
        end
        ISSUE: if (!trp_busy) begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) begin
            state_q <= WAIT;
            cnt_q   <= '0;
          end
        end
        // the counter is compared before incrementing, so a timeout lands TIMEOUT+1 cycles after WAIT entry
        WAIT: if (trp_valid) begin
          rsp_data <= trp_out;
          rsp_err  <= 1'b0;
          state_q  <= DONE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
          state_q  <= DONE;
        end else cnt_q <= cnt_q + 1'b1;
        DONE: if (rsp_ready) begin
          rsp_data <= '0;
          rsp_err  <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_trp_feeder.sv
// tb_trp_feeder: directed scoreboard bench for trp_feeder (beats and responses checked by independent monitors)
module tb_trp_feeder;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [1:0]   req_mode;
  logic [2:0]   req_len;
  logic [127:0] req_data;
  logic         trp_en, trp_read, trp_busy, trp_valid;
  logic [31:0]  trp_a, trp_out;
  logic [1:0]   trp_mode;
  logic         rsp_valid, rsp_ready, rsp_err, err;
  logic [31:0]  rsp_data;
  int vecs = 0;
  int miss = 0;
  logic [31:0] beat_q[$];
  logic [32:0] rsp_q[$];

  trp_feeder #(.WIDTH(4), .NBEATS(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_len(req_len), .req_data(req_data),
    .trp_en(trp_en), .trp_a(trp_a), .trp_mode(trp_mode), .trp_read(trp_read),
    .trp_busy(trp_busy), .trp_valid(trp_valid), .trp_out(trp_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && trp_en) begin
      if (beat_q.size() == 0) begin
        vecs++;
        miss++;
        $display("FAIL beat_unexpected: got %0h expected none", trp_a);
      end else chk("beat", trp_a, beat_q.pop_front());
    end
    if (!rst && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        vecs++;
        miss++;
        $display("FAIL rsp_unexpected: got %0h/%0b expected none", rsp_data, rsp_err);
      end else chk("rsp", {rsp_err, rsp_data}, rsp_q.pop_front());
    end
  end

  task automatic push_beats(input logic [127:0] d, input int n);
    for (int i = 0; i < n; i++) beat_q.push_back(d[32*i +: 32]);
  endtask

  task automatic send(input logic [1:0] m, input logic [2:0] l, input logic [127:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_mode  = m;
    req_len   = l;
    req_data  = d;
    while (!req_ready && n < 20) begin
      cyc();
      n++;
    end
    chk("send_ready", req_ready, 1);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic finish_wait(input logic [31:0] d);
    trp_valid = 1'b1;
    trp_out   = d;
    @(negedge clk);
    chk("trp_read", trp_read, 1);
    cyc();
    trp_valid = 1'b0;
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    cyc();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_trp_en"}, trp_en, 0);
    chk({tag, "_trp_a"}, trp_a, 0);
    chk({tag, "_trp_mode"}, trp_mode, 0);
    chk({tag, "_trp_read"}, trp_read, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic         bp[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         en[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0]  ea[6]  = '{32'h01010101, 32'h02020202, 32'h02020202, 32'h02020202, 32'h03030303, 32'h04040404};
    rst = 1'b1; req_valid = 1'b0; req_mode = '0; req_len = '0; req_data = '0;
    trp_busy = 1'b0; trp_valid = 1'b0; trp_out = '0; rsp_ready = 1'b1;
    @(negedge clk);
    check_reset("reset");
    cyc();
    rst = 1'b0;
    cyc();
    // basic: four back-to-back beats, result three cycles into WAIT
    d = 128'h44444444_33333333_22222222_11111111;
    push_beats(d, 4);
    rsp_q.push_back({1'b0, 32'h000000AA});
    send(2'b01, 3'd4, d);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("basic_en", trp_en, 1);
      chk("basic_mode", trp_mode, 2'b01);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("basic_wait_en", trp_en, 0);
      chk("basic_wait_read", trp_read, 0);
      cyc();
    end
    finish_wait(32'h000000AA);
    @(negedge clk);
    chk("basic_idle_ready", req_ready, 1);
    chk("basic_idle_mode", trp_mode, 0);
    // busy stall on the 2nd and 3rd ISSUE cycles
    d = 128'h04040404_03030303_02020202_01010101;
    push_beats(d, 4);
    rsp_q.push_back({1'b0, 32'h0000005A});
    cyc();
    send(2'b10, 3'd4, d);
    for (int i = 0; i < 6; i++) begin
      trp_busy = bp[i];
      @(negedge clk);
      chk("busy_en", trp_en, en[i]);
      chk("busy_a", trp_a, ea[i]);
      cyc();
    end
    trp_busy = 1'b0;
    finish_wait(32'h0000005A);
    // timeout: response 9 cycles after WAIT entry, then a stray result in IDLE
    push_beats(128'h77777777, 1);
    rsp_q.push_back({1'b1, 32'h0});
    send(2'b11, 3'd1, 128'h77777777);
    cyc();
    for (int w = 0; w < 9; w++) begin
      @(negedge clk);
      chk("timeout_pending", rsp_valid, 0);
      cyc();
    end
    @(negedge clk);
    chk("timeout_valid", rsp_valid, 1);
    chk("timeout_err", rsp_err, 1);
    chk("timeout_data", rsp_data, 0);
    cyc();
    trp_valid = 1'b1;
    trp_out   = 32'h00000BAD;
    @(negedge clk);
    chk("stray_read", trp_read, 0);
    chk("stray_err_before", err, 0);
    cyc();
    trp_valid = 1'b0;
    @(negedge clk);
    chk("stray_err_set", err, 1);
    for (int i = 0; i < 3; i++) cyc();
    @(negedge clk);
    chk("stray_err_sticky", err, 1);
    cyc();
    // length edges: zero length and over-length
    rsp_q.push_back({1'b1, 32'h0});
    send(2'b01, 3'd0, 128'hFFFF);
    @(negedge clk);
    chk("len0_valid", rsp_valid, 1);
    chk("len0_en", trp_en, 0);
    chk("len0_err", rsp_err, 1);
    cyc();
    d = 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1;
    push_beats(d, 4);
    rsp_q.push_back({1'b0, 32'h00003C3C});
    send(2'b10, 3'd7, d);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len7_en", trp_en, 1);
      cyc();
    end
    @(negedge clk);
    chk("len7_no_extra", trp_en, 0);
    cyc();
    finish_wait(32'h00003C3C);
    chk("err_still_set", err, 1);
    // response backpressure with the next request already waiting
    rsp_ready = 1'b0;
    d = 128'hB2B2B2B2_B1B1B1B1;
    push_beats(d, 2);
    rsp_q.push_back({1'b0, 32'h12345678});
    rsp_q.push_back({1'b1, 32'h0});
    send(2'b01, 3'd2, d);
    cyc();
    cyc();
    trp_valid = 1'b1;
    trp_out   = 32'h12345678;
    @(negedge clk);
    chk("bp_read", trp_read, 1);
    cyc();
    trp_valid = 1'b0;
    req_valid = 1'b1;
    req_len   = 3'd0;
    req_mode  = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 32'h12345678);
      chk("bp_err", rsp_err, 0);
      chk("bp_req_ready", req_ready, 0);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_req_ready", req_ready, 0);
    cyc();
    @(negedge clk);
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_ready", req_ready, 1);
    cyc();
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", rsp_valid, 1);
    chk("bp_next_err", rsp_err, 1);
    chk("bp_next_data", rsp_data, 0);
    cyc();
    // reset in the middle of ISSUE, then a fresh transaction
    d = 128'hE4E4E4E4_E3E3E3E3_E2E2E2E2_E1E1E1E1;
    push_beats(d, 2);
    send(2'b10, 3'd4, d);
    cyc();
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    cyc();
    rst = 1'b0;
    cyc();
    d = 128'h00000000_F3F3F3F3_F2F2F2F2_F1F1F1F1;
    push_beats(d, 3);
    rsp_q.push_back({1'b0, 32'h00C0FFEE});
    send(2'b11, 3'd3, d);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fresh_en", trp_en, 1);
      chk("fresh_mode", trp_mode, 2'b11);
      cyc();
    end
    finish_wait(32'h00C0FFEE);
    @(negedge clk);
    chk("fresh_err", err, 0);
    chk("beats_drained", beat_q.size(), 0);
    chk("rsps_drained", rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
